rx_pkt_check_ctrl: RTL and testbench
====================================

Name: rx_pkt_check_ctrl

Overview:
Synthesizable per-packet self-check sequencer for the RX AXIS path.
- On each packet-done strobe it computes the packet's byte window in the capture buffer.
- It walks that window one byte per cycle and compares received bytes against the expected (PHY-emulator) bytes wherever the ctrl flag is 1.
- It reports one pass or fail result per packet and keeps running statistics.
- It sits beside the RX AXIS master and drives the read ports of the received-data/ctrl memory and the expected-data memory.

Parameters:
BCNT_WIDTH, 32, width of rx_axis_mac_tbcnt
ADDR_WIDTH, 13, capture buffer address width (DEPTH = 2^ADDR_WIDTH = 8192)
OVERHEAD, 13, bytes added per packet: 8 preamble/SFD + 4 CRC + 1 FD
CNT_WIDTH, 32, width of pass/fail counters

Ports:
rx_mac_aclk  in  1  RX clock
reset_  in  1  asynchronous active-low reset
chk_en  in  1  accept new packets when 1
axis_rd_done_st  in  1  packet read-done level; its rising edge triggers a check
rx_axis_mac_tbcnt  in  BCNT_WIDTH  packet byte count, sampled at the trigger cycle
mem_rd_en  out  1  read strobe to both memories
mem_rd_addr  out  ADDR_WIDTH  byte address to both memories
rcv_data  in  8  received byte, valid 1 cycle after mem_rd_en
rcv_ctrl  in  1  received ctrl flag, valid 1 cycle after mem_rd_en
exp_data  in  8  expected byte, valid 1 cycle after mem_rd_en
chk_busy  out  1  high from trigger until the report cycle, inclusive
pkt_pass  out  1  1-cycle pulse: packet had no mismatch
pkt_fail  out  1  1-cycle pulse: mismatch or length error
pass_cnt  out  CNT_WIDTH  saturating count of passed packets
fail_cnt  out  CNT_WIDTH  saturating count of failed packets
first_err_addr  out  ADDR_WIDTH  address of the first mismatch in the last failed packet
first_err_exp  out  8  expected byte at first_err_addr
first_err_rcv  out  8  received byte at first_err_addr
len_err  out  1  1-cycle pulse with pkt_fail when the window exceeds DEPTH
overrun  out  1  sticky: trigger arrived while busy

Behaviour:
- Reset (async, reset_=0): FSM goes to IDLE. All outputs, start pointer, counters, first_err_* and overrun are 0. Edge-detect register is 0.
- Trigger: trig = axis_rd_done_st & ~done_dly1, where done_dly1 is registered on rx_mac_aclk. A held level triggers once only.
- Length: len = tbcnt + OVERHEAD, computed in BCNT_WIDTH+1 bits (no overflow).
- IDLE:
  - On trig & chk_en with len <= DEPTH: latch len into remaining, set addr = start, go to READ.
  - On trig & chk_en with len > DEPTH: no reads; go to REPORT with fail and len_err set.
  - In both cases, start <= (start + len) mod DEPTH at the trigger cycle.
  - On trig & !chk_en: ignored; start does not advance.
- READ:
  - mem_rd_en=1 each cycle; mem_rd_addr = addr; addr increments mod DEPTH (wrap 8191 -> 0).
  - remaining decrements each cycle; on the last read (remaining==1) go to DRAIN.
- Compare pipeline:
  - vld_d1 = mem_rd_en delayed by 1 cycle; addr_d1 delayed alongside.
  - When vld_d1 & rcv_ctrl & (rcv_data != exp_data): mark err.
  - On the first such error in the packet, latch addr_d1, exp_data and rcv_data into first_err_*.
  - Bytes with rcv_ctrl=0 are never compared.
- DRAIN: one cycle for the last compare, then go to REPORT.
- REPORT:
  - Pulse pkt_pass (err=0) or pkt_fail (err=1); increment the matching counter, saturating at all-ones.
  - Clear per-packet err and first-error-latched flags; go to IDLE.
  - first_err_* keep their value until the next failing packet overwrites them.
- Timing: trigger at cycle T → reads T+1..T+len → result pulse at T+len+2. chk_busy is high T..T+len+2.
- trig while not IDLE: ignored and overrun <= 1 (sticky until reset); start does not advance.
- chk_en dropping mid-packet: the current packet completes normally.
- Reset mid-packet: immediate IDLE; no pulse; counters cleared.

Decomposition:
- Package rx_chk_pkg holds:
  - FSM state enum {IDLE, READ, DRAIN, REPORT}
  - OVERHEAD and default ADDR_WIDTH constants
  - Counter saturation helper function
- One sub-module, rx_chk_byte_cmp, holds the registered compare stage (vld_d1/addr_d1, mismatch detect, first-error latch). Its inputs are a per-packet clear and the memory outputs; its outputs are err and first_err_*.

Test Plan:
- tbcnt=64, all bytes match, ctrl=1 → 77 reads at addr 0..76, pkt_pass at T+79, pass_cnt=1, next start=77.
- tbcnt=64, byte at addr 20 has exp 0xAA / rcv 0x55 with ctrl=1 → pkt_fail, first_err_addr=20, first_err_exp=0xAA, first_err_rcv=0x55, fail_cnt=1.
- Same mismatch at addr 20 but ctrl=0 → pkt_pass.
- Start preset by prior packets to 8180, tbcnt=20 → reads 8180..8191 then 0..20 (33 reads), next start=21.
- Second rising edge 5 cycles after a trigger → ignored, overrun=1, exactly one result pulse.
- tbcnt=8180 → len_err and pkt_fail pulse at T+1, zero reads.
- reset_=0 during READ → all outputs 0 at once, no result pulse.

Source files
------------

// File: rtl/rx_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_chk_pkg
// Brief    : Shared types and constants for the RX per-packet self-check.
// Revision : 1.0 - initial release
// ============================================================================
package rx_chk_pkg;

  localparam int c_OVERHEAD   = 13;
  localparam int c_ADDR_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } chk_state_t;

  // True while a counter of the given width is still below all-ones.
  function automatic logic cnt_can_inc(input logic [63:0] val, input int width);
    logic [63:0] lim;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val < lim);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_chk_byte_cmp.sv
`default_nettype none
// ============================================================================
// Module   : rx_chk_byte_cmp
// Brief    : Registered byte compare stage with first-mismatch capture.
// Revision : 1.0 - initial release
// ============================================================================
module rx_chk_byte_cmp #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [7:0]            i_rcv_data,
  input  logic                  i_rcv_ctrl,
  input  logic [7:0]            i_exp_data,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr,
  output logic [7:0]            o_first_err_exp,
  output logic [7:0]            o_first_err_rcv
);

  logic                  r_vld_d1;
  logic [ADDR_WIDTH-1:0] r_addr_d1;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_fe_addr;
  logic [7:0]            r_fe_exp;
  logic [7:0]            r_fe_rcv;
  logic                  w_mis;

  // Memory data arrives one cycle after the strobe; compare only flagged bytes.
  assign w_mis = r_vld_d1 & i_rcv_ctrl & (i_rcv_data != i_exp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_d1  <= 1'b0;
      r_addr_d1 <= '0;
      r_err     <= 1'b0;
      r_fe_addr <= '0;
      r_fe_exp  <= '0;
      r_fe_rcv  <= '0;
    end else begin
      r_vld_d1  <= i_rd_en;
      r_addr_d1 <= i_rd_addr;
      if (i_clr) begin
        r_err <= 1'b0;
      end else if (w_mis) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_fe_addr <= r_addr_d1;
          r_fe_exp  <= i_exp_data;
          r_fe_rcv  <= i_rcv_data;
        end
      end
    end
  end

  assign o_err            = r_err;
  assign o_first_err_addr = r_fe_addr;
  assign o_first_err_exp  = r_fe_exp;
  assign o_first_err_rcv  = r_fe_rcv;

endmodule
`default_nettype wire

// File: rtl/rx_pkt_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rx_pkt_check_ctrl
// Brief    : Per-packet RX capture-buffer self-check sequencer and statistics.
// Revision : 1.0 - initial release
// ============================================================================
module rx_pkt_check_ctrl
  import rx_chk_pkg::*;
#(
  parameter int BCNT_WIDTH = 32,
  parameter int ADDR_WIDTH = c_ADDR_WIDTH,
  parameter int OVERHEAD   = c_OVERHEAD,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rx_mac_aclk,
  input  logic                  reset_,
  input  logic                  chk_en,
  input  logic                  axis_rd_done_st,
  input  logic [BCNT_WIDTH-1:0] rx_axis_mac_tbcnt,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [7:0]            rcv_data,
  input  logic                  rcv_ctrl,
  input  logic [7:0]            exp_data,
  output logic                  chk_busy,
  output logic                  pkt_pass,
  output logic                  pkt_fail,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [7:0]            first_err_exp,
  output logic [7:0]            first_err_rcv,
  output logic                  len_err,
  output logic                  overrun
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LW    = BCNT_WIDTH + 1;

  chk_state_t            r_state;
  chk_state_t            w_next;
  logic                  r_done_dly1;
  logic                  w_trig;
  logic                  w_accept;
  logic [LW-1:0]         w_len;
  logic                  w_len_ok;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_len_err;
  logic [CNT_WIDTH-1:0]  r_pass_cnt;
  logic [CNT_WIDTH-1:0]  r_fail_cnt;
  logic                  r_overrun;
  logic                  w_err;

  assign w_trig   = axis_rd_done_st & ~r_done_dly1;
  assign w_len    = {1'b0, rx_axis_mac_tbcnt} + LW'(OVERHEAD);
  assign w_len_ok = (w_len <= LW'(DEPTH));
  assign w_accept = w_trig & chk_en & (r_state == IDLE);

  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_rd_en = 1'b0;
    pkt_pass  = 1'b0;
    pkt_fail  = 1'b0;
    len_err   = 1'b0;
    chk_busy  = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          chk_busy = 1'b1;
          w_next   = w_len_ok ? READ : REPORT;
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        if (r_remaining == (ADDR_WIDTH + 1)'(1)) w_next = DRAIN;
      end
      DRAIN:  w_next = REPORT;
      REPORT: begin
        pkt_pass = ~(w_err | r_len_err);
        pkt_fail = w_err | r_len_err;
        len_err  = r_len_err;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // The start pointer advances even for oversized packets so the window
  // tracking stays aligned with the capture writer.
  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) begin
      r_done_dly1 <= 1'b0;
      r_start     <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_len_err   <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_done_dly1 <= axis_rd_done_st;
      if (w_trig && (r_state != IDLE)) r_overrun <= 1'b1;
      if (w_accept) begin
        r_start     <= r_start + w_len[ADDR_WIDTH-1:0];
        r_addr      <= r_start;
        r_remaining <= w_len[ADDR_WIDTH:0];
        r_len_err   <= ~w_len_ok;
      end else if (r_state == READ) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - (ADDR_WIDTH + 1)'(1);
      end
      if (r_state == REPORT) begin
        r_len_err <= 1'b0;
        if (pkt_pass && cnt_can_inc(64'(r_pass_cnt), CNT_WIDTH))
          r_pass_cnt <= r_pass_cnt + CNT_WIDTH'(1);
        if (pkt_fail && cnt_can_inc(64'(r_fail_cnt), CNT_WIDTH))
          r_fail_cnt <= r_fail_cnt + CNT_WIDTH'(1);
      end
    end
  end

  rx_chk_byte_cmp #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_byte_cmp (
    .clk              (rx_mac_aclk),
    .rst_n            (reset_),
    .i_clr            (r_state == REPORT),
    .i_rd_en          (mem_rd_en),
    .i_rd_addr        (mem_rd_addr),
    .i_rcv_data       (rcv_data),
    .i_rcv_ctrl       (rcv_ctrl),
    .i_exp_data       (exp_data),
    .o_err            (w_err),
    .o_first_err_addr (first_err_addr),
    .o_first_err_exp  (first_err_exp),
    .o_first_err_rcv  (first_err_rcv)
  );

  assign mem_rd_addr = r_addr;
  assign pass_cnt    = r_pass_cnt;
  assign fail_cnt    = r_fail_cnt;
  assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_check_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_pkt_check_ctrl
// Brief    : Randomized self-checking bench for rx_pkt_check_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_pkt_check_ctrl;

  localparam int DEPTH = 8192;
  localparam int AW    = 13;
  localparam int BW    = 32;
  localparam int CW    = 32;
  localparam int OVH   = 13;

  logic          clk = 1'b0;
  logic          reset_;
  logic          chk_en;
  logic          done;
  logic [BW-1:0] tbcnt;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    rcv_data;
  logic          rcv_ctrl;
  logic [7:0]    exp_data;
  logic          chk_busy;
  logic          pkt_pass;
  logic          pkt_fail;
  logic [CW-1:0] pass_cnt;
  logic [CW-1:0] fail_cnt;
  logic [AW-1:0] first_err_addr;
  logic [7:0]    first_err_exp;
  logic [7:0]    first_err_rcv;
  logic          len_err;
  logic          overrun;

  always #5 clk = ~clk;

  rx_pkt_check_ctrl dut (
    .rx_mac_aclk       (clk),
    .reset_            (reset_),
    .chk_en            (chk_en),
    .axis_rd_done_st   (done),
    .rx_axis_mac_tbcnt (tbcnt),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .rcv_data          (rcv_data),
    .rcv_ctrl          (rcv_ctrl),
    .exp_data          (exp_data),
    .chk_busy          (chk_busy),
    .pkt_pass          (pkt_pass),
    .pkt_fail          (pkt_fail),
    .pass_cnt          (pass_cnt),
    .fail_cnt          (fail_cnt),
    .first_err_addr    (first_err_addr),
    .first_err_exp     (first_err_exp),
    .first_err_rcv     (first_err_rcv),
    .len_err           (len_err),
    .overrun           (overrun)
  );

  // Capture buffer and expected-data memories, one-cycle read latency.
  logic [7:0] rcv_mem  [DEPTH];
  logic [7:0] exp_mem  [DEPTH];
  logic       ctrl_mem [DEPTH];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      rcv_data <= rcv_mem[mem_rd_addr];
      rcv_ctrl <= ctrl_mem[mem_rd_addr];
      exp_data <= exp_mem[mem_rd_addr];
    end
  end

  // Reference state, kept from the packet rules alone.
  int         m_start;
  int         m_pass;
  int         m_fail;
  int         m_fe_addr;
  int         m_fe_exp;
  int         m_fe_rcv;
  bit         m_ovr;
  int         n_total;
  int         n_bad;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_start = 0; m_pass = 0; m_fail = 0;
    m_fe_addr = 0; m_fe_exp = 0; m_fe_rcv = 0; m_ovr = 0;
  endtask

  task automatic fill(input int len, input bit rnd);
    int a;
    for (int i = 0; i < len; i++) begin
      a = (m_start + i) % DEPTH;
      exp_mem[a]  = 8'($urandom);
      rcv_mem[a]  = exp_mem[a];
      ctrl_mem[a] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (rnd && ($urandom_range(0, 1) == 1)) begin
      repeat (2) begin
        a = (m_start + int'($urandom_range(0, len - 1))) % DEPTH;
        rcv_mem[a] = exp_mem[a] ^ 8'($urandom_range(1, 255));
      end
    end
  endtask

  task automatic run_pkt(input int cnt, input bit second_edge);
    int len    = cnt + OVH;
    bit lerr   = (len > DEPTH);
    int nreads = lerr ? 0 : len;
    int exp_pc = lerr ? 1 : len + 2;
    bit found  = 0;
    int fa = 0, fe = 0, fr = 0, a;
    int reads = 0, bad_addr = 0, pulses = 0, pcyc = -1, busy_bad = 0;
    bit ppass = 0, pfail = 0, plerr = 0;
    bit exp_fail;
    for (int i = 0; i < nreads; i++) begin
      a = (m_start + i) % DEPTH;
      if (!found && ctrl_mem[a] && (rcv_mem[a] != exp_mem[a])) begin
        found = 1; fa = a; fe = int'(exp_mem[a]); fr = int'(rcv_mem[a]);
      end
    end
    exp_fail = lerr | found;

    @(negedge clk);
    chk_en = 1'b1;
    tbcnt  = BW'(cnt);
    done   = 1'b1;
    #1 check("busy_at_trig", chk_busy, 1);
    for (int k = 1; k <= exp_pc + 6; k++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if ((int'(mem_rd_addr) != (m_start + reads) % DEPTH) || (k != reads + 1)) bad_addr++;
        reads++;
      end
      if (pkt_pass || pkt_fail) begin
        pulses++; pcyc = k; ppass = pkt_pass; pfail = pkt_fail; plerr = len_err;
      end
      if ((k <= exp_pc) != chk_busy) busy_bad++;
      if (k == 3) done = 1'b0;
      if (second_edge && k == 5) done = 1'b1;
      if (second_edge && k == 7) done = 1'b0;
    end

    m_start = (m_start + len) % DEPTH;
    if (exp_fail) m_fail++; else m_pass++;
    if (found) begin m_fe_addr = fa; m_fe_exp = fe; m_fe_rcv = fr; end
    if (second_edge) m_ovr = 1;

    check("read_count", reads, nreads);
    check("read_addr_errs", bad_addr, 0);
    check("pulse_count", pulses, 1);
    check("pulse_cycle", pcyc, exp_pc);
    check("pulse_pass", ppass, !exp_fail);
    check("pulse_fail", pfail, exp_fail);
    check("pulse_len_err", plerr, lerr);
    check("busy_window", busy_bad, 0);
    check("pass_cnt", pass_cnt, m_pass);
    check("fail_cnt", fail_cnt, m_fail);
    check("first_err_addr", first_err_addr, m_fe_addr);
    check("first_err_exp", first_err_exp, m_fe_exp);
    check("first_err_rcv", first_err_rcv, m_fe_rcv);
    check("overrun", overrun, m_ovr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    done   = 1'b0;
    reset_ = 1'b0;
    repeat (2) @(negedge clk);
    reset_ = 1'b1;
    model_clear();
  endtask

  initial begin
    int a, rd_seen, pulse_seen, busy_seen;
    n_total = 0; n_bad = 0;
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      rcv_mem[i] = 8'h00; exp_mem[i] = 8'h00; ctrl_mem[i] = 1'b0;
    end
    reset_ = 1'b0; chk_en = 1'b1; done = 1'b0; tbcnt = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_busy", chk_busy, 0);
    check("rst_pulses", {pkt_pass, pkt_fail, len_err}, 0);
    check("rst_cnts", {pass_cnt, fail_cnt}, 0);
    check("rst_first_err", {first_err_addr, first_err_exp, first_err_rcv}, 0);
    check("rst_overrun", overrun, 0);
    reset_ = 1'b1;

    // Clean packet: 77 reads from address 0.
    fill(77, 0);
    run_pkt(64, 0);

    // Reset while reading: everything clears, no result pulse.
    fill(77, 0);
    @(negedge clk);
    tbcnt = BW'(64); done = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) done = 1'b0;
    end
    check("rd_before_rst", mem_rd_en, 1);
    reset_ = 1'b0;
    #1;
    check("mid_rst_rd_en", mem_rd_en, 0);
    check("mid_rst_busy", chk_busy, 0);
    check("mid_rst_cnts", {pass_cnt, fail_cnt}, 0);
    check("mid_rst_overrun", overrun, 0);
    pulse_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (pkt_pass || pkt_fail) pulse_seen++;
    end
    check("mid_rst_no_pulse", pulse_seen, 0);
    reset_ = 1'b1;
    model_clear();

    // Mismatch at address 20, flagged and then unflagged.
    fill(77, 0);
    a = (m_start + 20) % DEPTH;
    exp_mem[a] = 8'hAA; rcv_mem[a] = 8'h55;
    run_pkt(64, 0);
    check("fe_addr_20", first_err_addr, 20);
    fill(77, 0);
    a = (m_start + 20) % DEPTH;
    exp_mem[a] = 8'hAA; rcv_mem[a] = 8'h55; ctrl_mem[a] = 1'b0;
    run_pkt(64, 0);

    // Second rising edge while busy.
    fill(77, 0);
    run_pkt(64, 1);

    // Trigger with checking disabled is ignored entirely.
    @(negedge clk);
    chk_en = 1'b0; tbcnt = BW'(40); done = 1'b1;
    rd_seen = 0; pulse_seen = 0; busy_seen = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_rd_en) rd_seen++;
      if (pkt_pass || pkt_fail) pulse_seen++;
      if (chk_busy) busy_seen++;
      if (k == 3) done = 1'b0;
    end
    chk_en = 1'b1;
    check("dis_reads", rd_seen, 0);
    check("dis_pulses", pulse_seen, 0);
    check("dis_busy", busy_seen, 0);

    for (int p = 0; p < 8; p++) begin
      int c = int'($urandom_range(0, 150));
      fill(c + OVH, 1);
      run_pkt(c, 0);
    end

    // Oversized packet moves the start to 8180, then a wrapping packet.
    do_reset();
    run_pkt(16359, 0);
    check("start_8180", m_start, 8180);
    fill(33, 1);
    run_pkt(20, 0);
    fill(20, 0);
    run_pkt(7, 0);
    run_pkt(8180, 0);
    fill(DEPTH, 1);
    run_pkt(DEPTH - OVH, 0);
    fill(50, 1);
    run_pkt(37, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
